// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
//   state_t  : controller state encoding
//   PCW_DEF  : default program-counter width (matches IF)
//   FCNT_W   : width of the flush-cycle counter (FLUSH_CYC up to 7)
package fetch_ctrl_pkg;

  localparam int PCW_DEF = 8;
  localparam int FCNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STALL,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-event and IF-control bundle around the fetch controller.
//   master : controller side (takes pipeline events, drives IF controls)
//   slave  : pipeline / IF side
//   inputs to controller : start, br_req, br_target, halt_req, stall_req
//   outputs of controller: branch, branch_adr, Halt, flush, done, cycle_cnt
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int PCW  = PCW_DEF,
  parameter int CNTW = 16
);

  logic           start;
  logic           br_req;
  logic [PCW-1:0] br_target;
  logic           halt_req;
  logic           stall_req;

  logic            branch;
  logic [PCW-1:0]  branch_adr;
  logic            Halt;
  logic            flush;
  logic            done;
  logic [CNTW-1:0] cycle_cnt;

  modport master (
    input  start, br_req, br_target, halt_req, stall_req,
    output branch, branch_adr, Halt, flush, done, cycle_cnt
  );

  modport slave (
    output start, br_req, br_target, halt_req, stall_req,
    input  branch, branch_adr, Halt, flush, done, cycle_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count one step this cycle
//   clear      : return to zero (wins over enable)
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  output logic [CNTW-1:0] count
);

  localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Sequencing controller for the instruction-fetch unit.
// Turns program start, taken branches, halts and data-memory stalls into
// IF's branch/branch_adr/Halt controls, a flush strobe, a done flag and an
// active-cycle counter.
//   CLK, Reset : clock, asynchronous active-low reset
//   bus        : fetch_ctrl_if master modport (events in, IF controls out)
//
//   state | meaning
//   IDLE  | after reset, PC held, waiting for start
//   RUN   | fetching, events evaluated by priority
//   STALL | data memory busy, PC held, a branch may be pending
//   FLUSH | branch issued, squashing FLUSH_CYC wrong-path slots
//   DONE  | halted, counter frozen, waiting for restart
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int             PCW       = PCW_DEF,
  parameter logic [PCW-1:0] START_ADR = '0,
  parameter int             FLUSH_CYC = 2,
  parameter int             CNTW      = 16
) (
  input logic         CLK,
  input logic         Reset,
  fetch_ctrl_if.master bus
);

  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYC - 1);

  state_t            state;
  logic [FCNT_W-1:0] flush_left;
  logic              pending;
  logic [PCW-1:0]    pending_adr;

  logic cnt_en;
  logic cnt_clr;

  assign cnt_en  = (state == RUN) || (state == STALL) || (state == FLUSH);
  assign cnt_clr = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      flush_left     <= '0;
      pending        <= 1'b0;
      pending_adr    <= '0;
      bus.branch     <= 1'b0;
      bus.branch_adr <= '0;
      bus.Halt       <= 1'b1;
      bus.flush      <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      // branch is a one-cycle strobe everywhere
      bus.branch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= RUN;
            bus.branch     <= 1'b1;
            bus.branch_adr <= START_ADR;
            bus.Halt       <= 1'b0;
            bus.done       <= 1'b0;
            bus.flush      <= 1'b0;
          end
        end

        RUN: begin
          if (bus.br_req && bus.stall_req) begin
            // branch must wait until memory frees up
            pending     <= 1'b1;
            pending_adr <= bus.br_target;
            state       <= STALL;
            bus.Halt    <= 1'b1;
          end else if (bus.br_req) begin
            // older branch wins over a same-cycle halt
            state          <= FLUSH;
            flush_left     <= FLUSH_LAST;
            bus.branch     <= 1'b1;
            bus.branch_adr <= bus.br_target;
            bus.flush      <= 1'b1;
            bus.Halt       <= 1'b0;
          end else if (bus.halt_req) begin
            state    <= DONE;
            bus.Halt <= 1'b1;
            bus.done <= 1'b1;
          end else if (bus.stall_req) begin
            state    <= STALL;
            bus.Halt <= 1'b1;
          end
        end

        STALL: begin
          if (!bus.stall_req) begin
            if (pending) begin
              pending        <= 1'b0;
              state          <= FLUSH;
              flush_left     <= FLUSH_LAST;
              bus.branch     <= 1'b1;
              bus.branch_adr <= pending_adr;
              bus.flush      <= 1'b1;
              bus.Halt       <= 1'b0;
            end else begin
              state    <= RUN;
              bus.Halt <= 1'b0;
            end
          end
        end

        FLUSH: begin
          // events here come from squashed instructions
          if (flush_left == '0) begin
            state     <= RUN;
            bus.flush <= 1'b0;
          end else begin
            flush_left <= flush_left - 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.Halt <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .CNTW (CNTW)
  ) u_cycle_cnt (
    .clk    (CLK),
    .rst_n  (Reset),
    .enable (cnt_en),
    .clear  (cnt_clr),
    .count  (bus.cycle_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int PCW       = 8;
  localparam int FLUSH_CYC = 2;
  localparam logic [7:0] START_ADR = 8'h00;

  logic CLK;
  logic Reset;

  fetch_ctrl_if #(.PCW(PCW), .CNTW(16)) bus ();
  fetch_ctrl_if #(.PCW(PCW), .CNTW(4))  bus4 ();

  fetch_ctrl #(.PCW(PCW), .START_ADR(START_ADR), .FLUSH_CYC(FLUSH_CYC), .CNTW(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  fetch_ctrl #(.PCW(PCW), .START_ADR(START_ADR), .FLUSH_CYC(FLUSH_CYC), .CNTW(4)) dut4 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: processor "running" flag, halted flag, stall flag,
  // remaining squash slots and a one-deep pending-branch slot.
  bit         m_active;
  bit         m_stalled;
  int         m_flush_left;
  logic [7:0] m_pend_q[$];
  int         m_cnt;
  bit         e_branch, e_halt, e_flush, e_done;
  logic [7:0] e_adr;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_stalled = 0; m_flush_left = 0; m_pend_q.delete();
    m_cnt = 0;
    e_branch = 0; e_halt = 1; e_flush = 0; e_done = 0; e_adr = '0;
  endtask

  task automatic take_branch(input logic [7:0] t);
    e_branch = 1; e_adr = t; e_flush = 1; e_halt = 0;
    m_flush_left = FLUSH_CYC;
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [7:0] t,
                            input bit h, input bit st);
    e_branch = 0;
    if (!m_active) begin
      if (s) begin
        m_active = 1; m_cnt = 0; m_stalled = 0; m_flush_left = 0;
        e_branch = 1; e_adr = START_ADR; e_halt = 0; e_done = 0; e_flush = 0;
      end
    end else begin
      m_cnt = sat(m_cnt + 1, 16);
      e_flush = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
        e_flush = (m_flush_left > 0);
      end else if (m_stalled) begin
        if (!st) begin
          m_stalled = 0;
          if (m_pend_q.size() > 0) take_branch(m_pend_q.pop_front());
          else e_halt = 0;
        end
      end else if (b && st) begin
        m_pend_q.push_back(t); m_stalled = 1; e_halt = 1;
      end else if (b) begin
        take_branch(t);
      end else if (h) begin
        m_active = 0; e_halt = 1; e_done = 1;
      end else if (st) begin
        m_stalled = 1; e_halt = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("branch",     32'(bus.branch),     32'(e_branch));
    chk("branch_adr", 32'(bus.branch_adr), 32'(e_adr));
    chk("halt",       32'(bus.Halt),       32'(e_halt));
    chk("flush",      32'(bus.flush),      32'(e_flush));
    chk("done",       32'(bus.done),       32'(e_done));
    chk("cycle_cnt",  32'(bus.cycle_cnt),  m_cnt);
    chk("cycle_cnt4", 32'(bus4.cycle_cnt), sat(m_cnt, 4));
    chk("inv_branch_halt", 32'(bus.branch & bus.Halt), 0);
    chk("inv_done_halt",   32'(bus.done & ~bus.Halt),  0);
  endtask

  task automatic drive(input bit s, input bit b, input logic [7:0] t,
                       input bit h, input bit st);
    bus.start = s;  bus.br_req = b;  bus.br_target = t;  bus.halt_req = h;  bus.stall_req = st;
    bus4.start = s; bus4.br_req = b; bus4.br_target = t; bus4.halt_req = h; bus4.stall_req = st;
  endtask

  task automatic step(input bit s, input bit b, input logic [7:0] t,
                      input bit h, input bit st);
    drive(s, b, t, h, st);
    @(posedge CLK);
    model_edge(s, b, t, h, st);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs();
    Reset = 1'b1;

    // no start: stays idle
    idle(5);
    chk("idle_halt", 32'(bus.Halt), 1);
    chk("idle_cnt",  32'(bus.cycle_cnt), 0);

    // start, then 10 RUN cycles
    step(1, 0, 8'h00, 0, 0);
    chk("start_branch", 32'(bus.branch), 1);
    chk("start_adr",    32'(bus.branch_adr), 32'(START_ADR));
    idle(10);
    chk("cnt_after_10", 32'(bus.cycle_cnt), 10);

    // branch, then a squashed branch during flush
    step(0, 1, 8'h40, 0, 0);
    chk("br40_adr", 32'(bus.branch_adr), 32'h40);
    step(0, 1, 8'h20, 0, 0);
    step(0, 1, 8'h20, 0, 0);
    chk("squashed_br", 32'(bus.branch), 0);
    idle(2);

    // branch during stall, released after 4 stalled cycles
    step(0, 1, 8'h80, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
    chk("stall_halt", 32'(bus.Halt), 1);
    step(0, 0, 8'h00, 0, 0);
    chk("pend_branch", 32'(bus.branch), 1);
    chk("pend_adr",    32'(bus.branch_adr), 32'h80);
    idle(3);

    // halt together with branch: branch wins
    step(0, 1, 8'h10, 1, 0);
    chk("br_over_halt", 32'(bus.done), 0);
    idle(3);
    step(0, 0, 8'h00, 1, 0);
    chk("halted_done", 32'(bus.done), 1);
    idle(4);
    step(1, 0, 8'h00, 0, 0);
    chk("restart_cnt", 32'(bus.cycle_cnt), 0);
    idle(2);

    // asynchronous reset while flushing
    step(0, 1, 8'h55, 0, 0);
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("arst_halt",   32'(bus.Halt), 1);
    chk("arst_branch", 32'(bus.branch), 0);
    chk("arst_flush",  32'(bus.flush), 0);
    chk("arst_adr",    32'(bus.branch_adr), 0);
    chk("arst_cnt",    32'(bus.cycle_cnt), 0);
    #1;
    Reset = 1'b1;

    // saturation of the narrow counter
    step(1, 0, 8'h00, 0, 0);
    idle(20);
    chk("sat4", 32'(bus4.cycle_cnt), 15);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0,
           8'($urandom_range(0, 255)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch unit (IF).
- Drives IF's branch, branch_adr and Halt inputs from pipeline events: program start, taken branches from execute, halt instructions from decode, and data-memory stalls.
- Produces a pipeline flush strobe and a done flag, and counts active cycles for performance measurement.

Parameters:
- PCW, 8, program-counter width; must match IF.
- START_ADR, 0, PC loaded on start.
- FLUSH_CYC, 2, bubble cycles squashed after a taken branch (range 1..7).
- CNTW, 16, width of the active-cycle counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart execution; sampled in IDLE and DONE only.
- br_req  in  1  taken branch resolved in execute.
- br_target  in  PCW  branch destination; valid with br_req.
- halt_req  in  1  halt instruction decoded.
- stall_req  in  1  data memory busy; freeze fetch.
- branch  out  1  to IF: load branch_adr into PC at the next edge.
- branch_adr  out  PCW  to IF: target address.
- Halt  out  1  to IF: hold PC.
- flush  out  1  squash the instruction in fetch/decode.
- done  out  1  processor halted.
- cycle_cnt  out  CNTW  active cycles since the last accepted start.

Behaviour:
- All outputs are registered.
- States: IDLE, RUN, STALL, FLUSH, DONE.
- Reset (asynchronous, Reset=0): state=IDLE, Halt=1, branch=0, branch_adr=0, flush=0, done=0, cycle_cnt=0, pending=0. Reset asserted mid-operation forces these values immediately, regardless of the clock.
- IDLE:
  - Outputs: Halt=1.
  - start=1 at edge k → state RUN; in cycle k+1, branch=1, branch_adr=START_ADR, Halt=0; cycle_cnt cleared to 0.
- RUN: Halt=0. Inputs are evaluated in priority order, first match wins:
  1. br_req and stall_req: latch br_target into pending register; → STALL.
  2. br_req: next cycle branch=1 (exactly one cycle), branch_adr=br_target, flush=1; → FLUSH. A simultaneous halt_req is discarded, because the branch is older.
  3. halt_req: → DONE; next cycle Halt=1, done=1.
  4. stall_req: → STALL; next cycle Halt=1.
- STALL:
  - Outputs: Halt=1, branch=0.
  - br_req and halt_req are ignored.
  - When stall_req=0: if pending, issue the branch exactly as in RUN item 2 and clear pending (→ FLUSH); otherwise → RUN with Halt=0 next cycle.
- FLUSH:
  - Outputs: flush=1 for exactly FLUSH_CYC consecutive cycles; Halt=0.
  - branch is high in the first FLUSH cycle only.
  - br_req, halt_req and stall_req are ignored, since they come from squashed instructions.
  - After the last flush cycle → RUN.
  - Consequence: a new branch is earliest FLUSH_CYC+1 cycles after the previous one.
- DONE:
  - Outputs: Halt=1, done=1.
  - cycle_cnt frozen.
  - start=1 restarts exactly as from IDLE; done clears in the cycle branch asserts.
- Invariants:
  - branch=1 implies Halt=0.
  - done=1 implies Halt=1.
  - branch_adr holds its last value when branch=0.
- cycle_cnt:
  - Increments once per cycle while state is RUN, STALL or FLUSH.
  - Saturates at 2^CNTW-1; no wrap.
  - Cleared on an accepted start.
- Widths: br_target and branch_adr are PCW bits, unsigned; no arithmetic is performed on the PC.

Decomposition:
- Package fetch_ctrl_pkg:
  - state enum typedef (IDLE, RUN, STALL, FLUSH, DONE).
  - PCW default.
  - flush-counter width constant, 3 bits.
- Sub-module sat_counter (parameter CNTW; ports: enable, clear, count) for cycle_cnt.
- The FSM and the pending-branch register stay in fetch_ctrl.

Test Plan:
- Reset low at t=0, released, no start for 5 cycles → Halt=1, branch=0, done=0, cycle_cnt=0 throughout.
- Pulse start with START_ADR=0 → next cycle branch=1, branch_adr=8'h00, Halt=0 for one cycle, then branch=0. cycle_cnt reads 10 after 10 RUN cycles.
- In RUN, br_req=1 with br_target=8'h40 for one cycle → next cycle branch=1, branch_adr=8'h40, flush=1 for 2 cycles; a br_req=1 with br_target=8'h20 during flush produces no branch.
- In RUN, stall_req=1 and br_req=1 (target 8'h80) together, stall held 4 cycles → Halt=1 for 4 cycles, no branch. The cycle after stall_req drops: branch=1, branch_adr=8'h80, flush=1.
- halt_req=1 together with br_req=1 (target 8'h10) → branch taken to 8'h10, done stays 0. A later lone halt_req → Halt=1, done=1, cycle_cnt frozen. start then restarts with cycle_cnt=0.
- Reset driven low between clock edges while in FLUSH → outputs reach reset values before the next edge. With CNTW=4, 20 RUN cycles → cycle_cnt=15 (saturated).
